// File: rtl/mma_drain_pkg.sv
// Shared defaults, derived sizes, slot indexing and drain FSM states for the
// MMA result drain.
package mma_drain_pkg;

  localparam int DEF_NUM_TC    = 2;
  localparam int DEF_NUM_OCTET = 2;
  localparam int DEF_NUM_TG    = 2;
  localparam int DEF_DATA_W    = 128;
  localparam int DEF_OUT_W     = 32;
  localparam int DEF_CNT_W     = 16;

  localparam int DEF_SLOTS = DEF_NUM_TC * DEF_NUM_OCTET * DEF_NUM_TG;
  localparam int DEF_BEATS = DEF_DATA_W / DEF_OUT_W;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  function automatic int slot_idx(input int tc, input int octet, input int tg,
                                  input int num_octet, input int num_tg);
    return ((tc * num_octet) + octet) * num_tg + tg;
  endfunction

  // Index width that never collapses to zero bits when only one value exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mma_drain_bank.sv
// One bundle-wide storage bank: whole-bundle write, OUT_W-wide indexed read.
module mma_drain_bank
  import mma_drain_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SLOT_W = 3,
  parameter int BEAT_W = 2
) (
  input  logic                      clock,
  input  logic                      i_we,
  input  logic [SLOTS*DATA_W-1:0]   i_data,
  input  logic [SLOT_W-1:0]         i_slot,
  input  logic [BEAT_W-1:0]         i_beat,
  output logic [OUT_W-1:0]          o_data
);

  localparam int BEATS = DATA_W / OUT_W;
  localparam int TOTAL = SLOTS * BEATS;
  localparam int IDX_W = idx_w(TOTAL);

  // Word k = slot*BEATS + beat, so the LSB beat of each slot is word 0 of it.
  logic [OUT_W-1:0] r_word [TOTAL];
  logic [IDX_W-1:0] w_idx;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int k = 0; k < TOTAL; k++) begin
        r_word[k] <= i_data[k*OUT_W +: OUT_W];
      end
    end
  end

  assign w_idx  = IDX_W'(i_slot) * IDX_W'(BEATS) + IDX_W'(i_beat);
  assign o_data = r_word[w_idx];

endmodule

// File: rtl/mma_result_drain.sv
// Double-buffered drain: accepts whole MMA result bundles and streams them out
// as OUT_W beats tagged with slot/beat indices, tolerant of back-pressure.
//
// state | meaning
// IDLE  | no bank being streamed; waits for full[rp]
// DRAIN | io_out_valid high, presenting bank[rp] at (slot, beat)
module mma_result_drain
  import mma_drain_pkg::*;
#(
  parameter int NUM_TC    = DEF_NUM_TC,
  parameter int NUM_OCTET = DEF_NUM_OCTET,
  parameter int NUM_TG    = DEF_NUM_TG,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         io_in_valid,
  output logic                                         io_in_ready,
  input  logic [NUM_TC*NUM_OCTET*NUM_TG*DATA_W-1:0]    io_in_bits,
  output logic                                         io_out_valid,
  input  logic                                         io_out_ready,
  output logic [OUT_W-1:0]                             io_out_bits,
  output logic [idx_w(NUM_TC*NUM_OCTET*NUM_TG)-1:0]    io_out_slot,
  output logic [idx_w(DATA_W/OUT_W)-1:0]               io_out_beat,
  output logic                                         io_out_last,
  output logic                                         io_busy,
  output logic [CNT_W-1:0]                             io_done_cnt
);

  localparam int SLOTS  = slot_idx(NUM_TC-1, NUM_OCTET-1, NUM_TG-1, NUM_OCTET, NUM_TG) + 1;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam int SLOT_W = idx_w(SLOTS);
  localparam int BEAT_W = idx_w(BEATS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (DATA_W % OUT_W != 0) begin : g_bad_out_w
    $error("mma_result_drain: DATA_W must be a multiple of OUT_W");
  end

  drain_state_t       r_state, w_state_nxt;
  logic [1:0]         r_full, w_full_nxt;
  logic               r_wp, w_wp_nxt;
  logic               r_rp, w_rp_nxt;
  logic [SLOT_W-1:0]  r_slot, w_slot_nxt;
  logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
  logic [CNT_W-1:0]   r_done_cnt, w_cnt_nxt;

  logic               w_in_fire;
  logic               w_last;
  logic [1:0]         w_we;
  logic [OUT_W-1:0]   w_bank_data [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mma_drain_bank #(
      .SLOTS  (SLOTS),
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W),
      .SLOT_W (SLOT_W),
      .BEAT_W (BEAT_W)
    ) u_bank (
      .clock  (clock),
      .i_we   (w_we[g]),
      .i_data (io_in_bits),
      .i_slot (r_slot),
      .i_beat (r_beat),
      .o_data (w_bank_data[g])
    );
  end

  assign io_in_ready  = !r_full[r_wp];
  assign w_in_fire    = io_in_valid && io_in_ready;
  assign w_we[0]      = w_in_fire && !reset && (r_wp == 1'b0);
  assign w_we[1]      = w_in_fire && !reset && (r_wp == 1'b1);

  assign io_out_valid = (r_state == DRAIN);
  assign w_last       = io_out_valid && (r_slot == LAST_SLOT) && (r_beat == LAST_BEAT);
  assign io_out_last  = w_last;
  assign io_out_bits  = r_rp ? w_bank_data[1] : w_bank_data[0];
  assign io_out_slot  = r_slot;
  assign io_out_beat  = r_beat;
  assign io_busy      = |r_full;
  assign io_done_cnt  = r_done_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_full_nxt  = r_full;
    w_wp_nxt    = r_wp;
    w_rp_nxt    = r_rp;
    w_slot_nxt  = r_slot;
    w_beat_nxt  = r_beat;
    w_cnt_nxt   = r_done_cnt;

    // Set and clear never target the same bank: set needs !full[wp], clear needs full[rp].
    if (w_in_fire) begin
      w_full_nxt[r_wp] = 1'b1;
      w_wp_nxt         = ~r_wp;
    end

    case (r_state)
      IDLE: begin
        if (r_full[r_rp]) begin
          w_state_nxt = DRAIN;
          w_slot_nxt  = '0;
          w_beat_nxt  = '0;
        end
      end
      DRAIN: begin
        if (io_out_ready) begin
          if (w_last) begin
            w_full_nxt[r_rp] = 1'b0;
            w_rp_nxt         = ~r_rp;
            w_cnt_nxt        = r_done_cnt + 1'b1;
            w_slot_nxt       = '0;
            w_beat_nxt       = '0;
            w_state_nxt      = r_full[~r_rp] ? DRAIN : IDLE;
          end else if (r_beat == LAST_BEAT) begin
            w_beat_nxt = '0;
            w_slot_nxt = r_slot + 1'b1;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_full     <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_slot     <= '0;
      r_beat     <= '0;
      r_done_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_full     <= w_full_nxt;
      r_wp       <= w_wp_nxt;
      r_rp       <= w_rp_nxt;
      r_slot     <= w_slot_nxt;
      r_beat     <= w_beat_nxt;
      r_done_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/mma_result_drain.md
Name: mma_result_drain

Overview:
- Parametrised, double-buffered result drain between the tensor-core array and the system output port.
- Accepts one complete MMA result bundle (every tc × octet × threadgroup matrix_d_data word) per handshake.
- Serialises each bundle into narrow OUT_W beats on a ready/valid stream, tagged with slot and beat indices.
- Replaces the fixed eight-wide parallel matrix_d output with a configurable, back-pressure-tolerant stream.

Parameters:
- NUM_TC, 2, tensor cores per bundle.
- NUM_OCTET, 2, octets per tensor core.
- NUM_TG, 2, captured threadgroups per octet.
- DATA_W, 128, bits of matrix_d_data per threadgroup slot.
- OUT_W, 32, output beat width; DATA_W % OUT_W == 0 is required, else elaboration error.
- CNT_W, 16, width of the completed-bundle counter.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  1  bundle valid.
- io_in_ready  out  1  a bank is free.
- io_in_bits  in  NUM_TC*NUM_OCTET*NUM_TG*DATA_W  flattened bundle; slot s = ((tc*NUM_OCTET)+octet)*NUM_TG+tg occupies bits [s*DATA_W +: DATA_W].
- io_out_valid  out  1  beat valid.
- io_out_ready  in  1  downstream accepts beat.
- io_out_bits  out  OUT_W  beat data.
- io_out_slot  out  clog2(SLOTS)  slot index of the current beat.
- io_out_beat  out  clog2(BEATS)  beat index within the slot.
- io_out_last  out  1  final beat of the bundle.
- io_busy  out  1  either bank full.
- io_done_cnt  out  CNT_W  bundles fully drained; wraps modulo 2^CNT_W.

Behaviour:
- Derived constants:
  - SLOTS = NUM_TC*NUM_OCTET*NUM_TG.
  - BEATS = DATA_W/OUT_W.
  - TOTAL = SLOTS*BEATS.
- Storage: two banks, each SLOTS*DATA_W wide. Per-bank full flag. Write pointer wp and read pointer rp, 1 bit each.
- Reset (synchronous, evaluated before all other updates):
  - Both full flags cleared.
  - wp = rp = 0.
  - Slot and beat counters = 0.
  - io_done_cnt = 0.
  - Outputs: io_out_valid=0, io_in_ready=1, io_busy=0, io_out_last=0.
  - Bank contents are not reset.
  - Reset mid-drain discards both banks; nothing further is emitted.
- Input side:
  - io_in_ready = !full[wp], computed from registered state only.
  - On io_in_valid && io_in_ready: bank[wp] <= io_in_bits, full[wp] <= 1, wp toggles.
- Output side FSM, states IDLE and DRAIN:
  - IDLE: io_out_valid=0. When full[rp], go to DRAIN with slot=0, beat=0.
  - IDLE→DRAIN takes one cycle. The first beat is valid the cycle after the bank becomes full, so input-to-first-beat latency is 2 cycles.
  - DRAIN: io_out_valid=1.
  - io_out_bits = bank[rp][slot*DATA_W + beat*OUT_W +: OUT_W]. Order is slot ascending, and within a slot the LSB beat first.
  - io_out_last = (slot==SLOTS-1 && beat==BEATS-1).
  - On handshake, beat increments; at BEATS-1 it wraps to 0 and slot increments.
  - On a handshake with last asserted:
    - full[rp] <= 0, rp toggles, io_done_cnt++.
    - Next state is DRAIN at slot=0, beat=0 if the other bank is full, otherwise IDLE. Back-to-back bundles therefore have no bubble.
  - While DRAIN with io_out_ready=0, all output signals hold stable (AXI-style); no valid de-assertion is allowed.
- Simultaneous events:
  - A last-beat handshake freeing bank[rp] in the same cycle an input arrives for the other bank: both take effect.
  - A bank freed this cycle is not visible to io_in_ready until the next cycle.
- Both banks full: io_in_ready=0 and io_in_bits is ignored.
- io_busy = full[0] | full[1].
- Counter wrap: io_done_cnt goes from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package mma_drain_pkg holds:
  - default NUM_TC / NUM_OCTET / NUM_TG / DATA_W / OUT_W;
  - derived SLOTS / BEATS localparams;
  - the slot-index function (tc, octet, tg → s);
  - the FSM state enum {IDLE, DRAIN}.
- One natural sub-module, mma_drain_bank: a single bank register with a write-enable and an indexed OUT_W read mux. Instantiate it twice; the top holds the pointers, FSM and counters.

Test Plan:
- Reset: hold reset 2 cycles → io_in_ready=1, io_out_valid=0, io_busy=0, io_done_cnt=0.
- Single bundle with defaults, slot s word = {4{8'h10+s}}, io_out_ready=1 → first valid 2 cycles after the accept; 32 beats in slot 0..7 / beat 0..3 order; beat 0 = 32'h10101010; io_out_last only on beat 32; io_done_cnt=1; io_busy=0 afterward.
- Back-pressure: io_out_ready toggles 1,0,0,1 → beat data, slot and beat indices stay stable while stalled; no beat lost or duplicated; 32 beats total.
- Full banks: push 3 bundles back-to-back with io_out_ready=0 → the first two are accepted and io_in_ready=0 on the third. Then set io_out_ready=1 → 64 contiguous valid beats with no bubble between bundles; the third bundle is accepted the cycle after bank 0 frees.
- Reset mid-drain: assert reset at beat 10 of bundle 1 with bundle 2 queued → next cycle io_out_valid=0, io_busy=0, io_done_cnt=0, and no further beats appear.
- Parameter sweep NUM_TC=1, NUM_TG=1, DATA_W=64, OUT_W=64 → BEATS=1, io_out_beat is constant 0; 2 beats per bundle, with last on the 2nd.
